// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every bus signal around the memory arbiter: the CPU instruction-fetch
// port, the CPU data port and the shared external memory port.
//
// Signal summary (names as seen from the arbiter):
//   Fetch port : i_rd_i, i_addr_i        -> o_data_in_i, o_valid_i
//   Data port  : i_rd_d, i_wr_d[3:0], i_addr_d, i_data_wr_d
//                                        -> o_data_rd_d, o_valid_d
//   Status     : o_err (qualifies o_valid_i / o_valid_d on a watchdog abort)
//   Memory     : o_mem_addr, o_mem_rd, o_mem_wr[3:0], o_mem_data_wr
//                                        <- i_mem_data_rd, i_mem_ack
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment around it (CPU ports plus memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  localparam int DATA_W = 32;

  // Instruction-fetch port
  logic                  i_rd_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic [DATA_W-1:0]     o_data_in_i;
  logic                  o_valid_i;

  // Data port
  logic                  i_rd_d;
  logic [3:0]            i_wr_d;
  logic [ADDR_WIDTH-1:0] i_addr_d;
  logic [DATA_W-1:0]     i_data_wr_d;
  logic [DATA_W-1:0]     o_data_rd_d;
  logic                  o_valid_d;

  // Abort status
  logic                  o_err;

  // Shared memory port
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_rd;
  logic [3:0]            o_mem_wr;
  logic [DATA_W-1:0]     o_mem_data_wr;
  logic [DATA_W-1:0]     i_mem_data_rd;
  logic                  i_mem_ack;

  modport slave (
    input  i_rd_i, i_addr_i,
    input  i_rd_d, i_wr_d, i_addr_d, i_data_wr_d,
    input  i_mem_data_rd, i_mem_ack,
    output o_data_in_i, o_valid_i,
    output o_data_rd_d, o_valid_d,
    output o_err,
    output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_data_wr
  );

  modport master (
    output i_rd_i, i_addr_i,
    output i_rd_d, i_wr_d, i_addr_d, i_data_wr_d,
    output i_mem_data_rd, i_mem_ack,
    input  o_data_in_i, o_valid_i,
    input  o_data_rd_d, o_valid_d,
    input  o_err,
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_data_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one external memory port between the CPU instruction-fetch port and
// the CPU data port. One transaction is in flight at a time; when both ports
// request in the same IDLE cycle the port that was not granted last wins.
// Memory strobes, address and write data are registered at grant and held
// until the memory acknowledges; the owner then gets a one-cycle valid pulse
// with its read data. A watchdog aborts a transaction that is never
// acknowledged and flags the abort on o_err alongside the valid pulse.
//
// Parameters:
//   ADDR_WIDTH - width of all address buses
//   TIMEOUT    - busy cycles allowed before abort; 0 disables the watchdog
//
// Ports:
//   i_clk - clock, all logic on the rising edge
//   i_rst - synchronous active-high reset
//   bus   - mem_arbiter_if.slave carrying the fetch, data and memory ports
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires on the TIMEOUT-th busy cycle, i.e. when the counter
  // (cleared at grant, +1 per unacknowledged busy cycle) sits at TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit WDOG_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Control state
  state_t             state_q, state_d;
  grant_t             last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Memory-side registers
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [3:0]            mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  // CPU-side registers
  logic [DATA_W-1:0]     fetch_data_q, fetch_data_d;
  logic                  fetch_vld_q, fetch_vld_d;
  logic [DATA_W-1:0]     dport_data_q, dport_data_d;
  logic                  dport_vld_q, dport_vld_d;
  logic                  err_q, err_d;

  logic req_i;
  logic req_d;
  logic d_is_wr;
  logic pick_d;
  logic wdog_hit;

  assign req_i   = bus.i_rd_i;
  assign d_is_wr = |bus.i_wr_d;
  assign req_d   = bus.i_rd_d | d_is_wr;

  // Data wins when it is the only requester, or on a tie when fetch went last.
  assign pick_d  = req_d & (~req_i | (last_q == GNT_I));

  assign wdog_hit = WDOG_EN && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_wdata_d  = mem_wdata_q;
    fetch_data_d = fetch_data_q;
    dport_data_d = dport_data_q;
    fetch_vld_d  = 1'b0;
    dport_vld_d  = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // i_mem_ack is deliberately ignored here: nothing is outstanding.
        if (pick_d) begin
          state_d     = S_BUSY_D;
          last_d      = GNT_D;
          cnt_d       = '0;
          mem_addr_d  = bus.i_addr_d;
          // Any byte enable makes it a write, even with i_rd_d also high.
          mem_rd_d    = ~d_is_wr;
          mem_wr_d    = bus.i_wr_d;
          mem_wdata_d = bus.i_data_wr_d;
        end else if (req_i) begin
          state_d     = S_BUSY_I;
          last_d      = GNT_I;
          cnt_d       = '0;
          mem_addr_d  = bus.i_addr_i;
          mem_rd_d    = 1'b1;
          mem_wr_d    = 4'b0000;
          mem_wdata_d = '0;
        end
      end

      S_BUSY_I, S_BUSY_D: begin
        // Ack takes priority over a watchdog expiry in the same cycle.
        if (bus.i_mem_ack || wdog_hit) begin
          state_d     = S_IDLE;
          mem_addr_d  = '0;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 4'b0000;
          mem_wdata_d = '0;
          err_d       = ~bus.i_mem_ack;
          if (state_q == S_BUSY_I) begin
            fetch_vld_d  = 1'b1;
            fetch_data_d = bus.i_mem_ack ? bus.i_mem_data_rd : '0;
          end else begin
            dport_vld_d  = 1'b1;
            // Writes and aborted accesses return zero on the data port.
            dport_data_d = (bus.i_mem_ack && mem_rd_q) ? bus.i_mem_data_rd : '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        mem_addr_d  = '0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 4'b0000;
        mem_wdata_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_q       <= GNT_I;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      fetch_data_q <= '0;
      fetch_vld_q  <= 1'b0;
      dport_data_q <= '0;
      dport_vld_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_data_q <= fetch_data_d;
      fetch_vld_q  <= fetch_vld_d;
      dport_data_q <= dport_data_d;
      dport_vld_q  <= dport_vld_d;
      err_q        <= err_d;
    end
  end

  assign bus.o_data_in_i   = fetch_data_q;
  assign bus.o_valid_i     = fetch_vld_q;
  assign bus.o_data_rd_d   = dport_data_q;
  assign bus.o_valid_d     = dport_vld_q;
  assign bus.o_err         = err_q;
  assign bus.o_mem_addr    = mem_addr_q;
  assign bus.o_mem_rd      = mem_rd_q;
  assign bus.o_mem_wr      = mem_wr_q;
  assign bus.o_mem_data_wr = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters share one stimulus: dut_a (default watchdog) and dut_b
// (TIMEOUT=4). "sel" picks which one the memory responder, the monitor and
// the checks look at. Completions are checked by a scoreboard queue filled
// when requests are driven.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 32;

  logic clk;
  logic rst;
  logic sel;

  logic        rd_i, rd_d;
  logic [31:0] addr_i, addr_d, wdata_d;
  logic [3:0]  wr_d;
  logic        ack, ack_force;
  logic [31:0] mem_rdata;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus_a ();
  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.i_rd_i        = rd_i;
  assign bus_a.i_addr_i      = addr_i;
  assign bus_a.i_rd_d        = rd_d;
  assign bus_a.i_wr_d        = wr_d;
  assign bus_a.i_addr_d      = addr_d;
  assign bus_a.i_data_wr_d   = wdata_d;
  assign bus_a.i_mem_data_rd = mem_rdata;
  assign bus_a.i_mem_ack     = ack | ack_force;

  assign bus_b.i_rd_i        = rd_i;
  assign bus_b.i_addr_i      = addr_i;
  assign bus_b.i_rd_d        = rd_d;
  assign bus_b.i_wr_d        = wr_d;
  assign bus_b.i_addr_d      = addr_d;
  assign bus_b.i_data_wr_d   = wdata_d;
  assign bus_b.i_mem_data_rd = mem_rdata;
  assign bus_b.i_mem_ack     = ack | ack_force;

  mem_arbiter #(.ADDR_WIDTH(AW)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(4)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Selected DUT outputs
  logic [31:0] o_din_i, o_drd_d, o_maddr, o_mwdata;
  logic        o_vi, o_vd, o_err, o_mrd;
  logic [3:0]  o_mwr;

  always_comb begin
    if (sel) begin
      o_din_i = bus_b.o_data_in_i; o_vi  = bus_b.o_valid_i;
      o_drd_d = bus_b.o_data_rd_d; o_vd  = bus_b.o_valid_d;
      o_err   = bus_b.o_err;       o_maddr = bus_b.o_mem_addr;
      o_mrd   = bus_b.o_mem_rd;    o_mwr = bus_b.o_mem_wr;
      o_mwdata = bus_b.o_mem_data_wr;
    end else begin
      o_din_i = bus_a.o_data_in_i; o_vi  = bus_a.o_valid_i;
      o_drd_d = bus_a.o_data_rd_d; o_vd  = bus_a.o_valid_d;
      o_err   = bus_a.o_err;       o_maddr = bus_a.o_mem_addr;
      o_mrd   = bus_a.o_mem_rd;    o_mwr = bus_a.o_mem_wr;
      o_mwdata = bus_a.o_mem_data_wr;
    end
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents model
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {~a[15:0], a[15:0]};
  endfunction

  // Memory responder: acks after ack_delay busy cycles without ack.
  bit ack_en;
  int ack_delay;
  int busy_cnt = 0;

  always @(negedge clk) begin
    ack       = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    if (o_mrd || (|o_mwr)) begin
      if (ack_en && busy_cnt == ack_delay) begin
        ack       = 1'b1;
        mem_rdata = rdata_of(o_maddr);
      end
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  // Scoreboard
  typedef struct {
    bit          port_d;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_txn(input bit pd, input logic [31:0] d, input bit e);
    exp_t x;
    x.port_d = pd;
    x.data   = d;
    x.err    = e;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (o_vi || o_vd) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {o_vi, o_vd}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_port", {o_vi, o_vd}, e.port_d ? 2'b01 : 2'b10);
        chk("rdata", e.port_d ? o_drd_d : o_din_i, e.data);
        chk("err", o_err, e.err);
      end
    end else if (o_err) begin
      chk("err_without_valid", o_err, 1'b0);
    end
  end

  // Single-transaction vectors
  typedef struct {
    bit          rd_i;
    logic [31:0] addr_i;
    bit          rd_d;
    logic [3:0]  wr_d;
    logic [31:0] addr_d;
    logic [31:0] wdata;
    int          delay;
    bit          e_port_d;
    bit          e_rd;
    logic [3:0]  e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
  } vec_t;
  vec_t vecs [6];

  task automatic do_reset();
    rst = 1'b1;
    rd_i = 1'b0; rd_d = 1'b0; wr_d = 4'h0;
    addr_i = '0; addr_d = '0; wdata_d = '0;
    ack_force = 1'b0; ack_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(o_vi || o_vd) && n < max);
    if (!(o_vi || o_vd)) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: no valid within %0d cycles", name, max);
    end
  endtask

  // Counts busy cycles until completion, then drops all requests.
  task automatic run_count(input string name, input int exp_busy);
    int n;
    int busy;
    n = 0;
    busy = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_mrd || (|o_mwr)) busy++;
    end while (!(o_vi || o_vd) && n < 30);
    chk({name, "_valid"}, o_vi | o_vd, 1'b1);
    chk({name, "_busy_cycles"}, busy, exp_busy);
    rd_i = 1'b0; rd_d = 1'b0; wr_d = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "bench stopped");
  end

  initial begin
    logic [31:0] last_i;
    logic [31:0] last_d;

    //            rd_i addr_i     rd_d wr_d  addr_d      wdata          dly port rd  wr    addr          wdata          data
    vecs[0] = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0,    32'h0,         2, 1'b0, 1'b1, 4'h0, 32'h100,  32'h0,         rdata_of(32'h100)};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 4'h0, 32'h8000, 32'h0,         0, 1'b1, 1'b1, 4'h0, 32'h8000, 32'h0,         rdata_of(32'h8000)};
    vecs[2] = '{1'b0, 32'h0,   1'b0, 4'h2, 32'h40,   32'hAABBCCDD,  1, 1'b1, 1'b0, 4'h2, 32'h40,   32'hAABBCCDD,  32'h0};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 4'hF, 32'h44,   32'h12345678,  0, 1'b1, 1'b0, 4'hF, 32'h44,   32'h12345678,  32'h0};
    vecs[4] = '{1'b1, 32'h104, 1'b0, 4'h0, 32'h0,    32'h0,         3, 1'b0, 1'b1, 4'h0, 32'h104,  32'h0,         rdata_of(32'h104)};
    vecs[5] = '{1'b0, 32'h0,   1'b1, 4'h0, 32'hFFFC, 32'h0,         1, 1'b1, 1'b1, 4'h0, 32'hFFFC, 32'h0,         rdata_of(32'hFFFC)};

    sel = 1'b0;
    ack_delay = 0;
    do_reset();

    // Reset state
    chk("rst_strobes", {o_mrd, o_mwr}, 64'd0);
    chk("rst_bus", {o_maddr, o_mwdata}, 64'd0);
    chk("rst_valids", {o_vi, o_vd, o_err}, 64'd0);
    chk("rst_data", {o_din_i, o_drd_d}, 64'd0);

    // Contention right after reset: data first, then alternate
    rd_i = 1'b1; addr_i = 32'h200;
    rd_d = 1'b1; addr_d = 32'h8000; wr_d = 4'h0; wdata_d = '0;
    ack_en = 1'b1; ack_delay = 0;
    expect_txn(1'b1, rdata_of(32'h8000), 1'b0);
    expect_txn(1'b0, rdata_of(32'h200),  1'b0);
    expect_txn(1'b1, rdata_of(32'h8000), 1'b0);
    expect_txn(1'b0, rdata_of(32'h200),  1'b0);
    for (int t = 0; t < 4; t++) wait_valid("contend", 10);
    rd_i = 1'b0; rd_d = 1'b0;
    @(negedge clk);
    chk("contend_drained", exp_q.size(), 0);
    last_i = rdata_of(32'h200);
    last_d = rdata_of(32'h8000);

    // Table-driven single transactions
    for (int k = 0; k < 6; k++) begin
      rd_i = vecs[k].rd_i; addr_i = vecs[k].addr_i;
      rd_d = vecs[k].rd_d; wr_d = vecs[k].wr_d;
      addr_d = vecs[k].addr_d; wdata_d = vecs[k].wdata;
      ack_en = 1'b1; ack_delay = vecs[k].delay;
      expect_txn(vecs[k].e_port_d, vecs[k].e_data, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_strobes", k), {o_mrd, o_mwr}, {vecs[k].e_rd, vecs[k].e_wr});
      chk($sformatf("v%0d_addr", k), o_maddr, vecs[k].e_addr);
      chk($sformatf("v%0d_wdata", k), o_mwdata, vecs[k].e_wdata);
      wait_valid($sformatf("v%0d", k), 20);
      rd_i = 1'b0; rd_d = 1'b0; wr_d = 4'h0;
      if (vecs[k].e_port_d) begin
        chk($sformatf("v%0d_hold_fetch_data", k), o_din_i, last_i);
        last_d = vecs[k].e_data;
      end else begin
        chk($sformatf("v%0d_hold_dport_data", k), o_drd_d, last_d);
        last_i = vecs[k].e_data;
      end
      @(negedge clk);
      chk($sformatf("v%0d_drained", k), exp_q.size(), 0);
    end

    // Held strobes while the data requester changes its inputs
    wr_d = 4'hF; addr_d = 32'h300; wdata_d = 32'h1111_2222;
    ack_en = 1'b1; ack_delay = 5;
    expect_txn(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("stable_start", {o_maddr, o_mwdata}, {32'h300, 32'h1111_2222});
    for (int t = 0; t < 5; t++) begin
      addr_d  = $urandom;
      wdata_d = $urandom;
      @(negedge clk);
      chk($sformatf("stable_%0d", t), {o_maddr, o_mwdata, 28'd0, o_mwr}, {32'h300, 32'h1111_2222, 28'd0, 4'hF});
    end
    wait_valid("stable", 10);
    wr_d = 4'h0;
    @(negedge clk);

    // Reset in the middle of a fetch
    ack_en = 1'b0;
    rd_i = 1'b1; addr_i = 32'h500;
    @(negedge clk);
    chk("rmo_busy", {o_mrd, o_maddr}, {1'b1, 32'h500});
    rst = 1'b1; rd_i = 1'b0;
    @(negedge clk);
    chk("rmo_strobes", {o_mrd, o_mwr, o_maddr}, 64'd0);
    chk("rmo_valids", {o_vi, o_vd, o_err}, 64'd0);
    rst = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    chk("rmo_late_ack", {o_vi, o_vd, o_mrd, o_mwr}, 64'd0);
    rd_i = 1'b1; addr_i = 32'h200;
    rd_d = 1'b1; addr_d = 32'h8000;
    ack_en = 1'b1; ack_delay = 0;
    expect_txn(1'b1, rdata_of(32'h8000), 1'b0);
    expect_txn(1'b0, rdata_of(32'h200),  1'b0);
    @(negedge clk);
    chk("rmo_first_grant", {o_mrd, o_maddr}, {1'b1, 32'h8000});
    wait_valid("rmo_d", 10);
    wait_valid("rmo_i", 10);
    rd_i = 1'b0; rd_d = 1'b0;
    @(negedge clk);
    chk("rmo_drained", exp_q.size(), 0);

    // Watchdog on the TIMEOUT=4 instance
    sel = 1'b1;
    do_reset();
    rd_d = 1'b1; addr_d = 32'h604;
    ack_en = 1'b1; ack_delay = 3;
    expect_txn(1'b1, rdata_of(32'h604), 1'b0);
    run_count("to_ack_last", 4);

    rd_d = 1'b1; addr_d = 32'h608;
    ack_en = 1'b0;
    expect_txn(1'b1, 32'h0, 1'b1);
    run_count("to_dport", 4);

    rd_i = 1'b1; addr_i = 32'h700;
    expect_txn(1'b0, 32'h0, 1'b1);
    run_count("to_fetch", 4);

    @(negedge clk);
    chk("to_strobes_idle", {o_mrd, o_mwr, o_err}, 64'd0);
    chk("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one external memory port between the CPU instruction-fetch port and the CPU data port.
- Grants one transaction at a time, with round-robin priority under contention.
- Holds the memory strobes stable until acknowledged, then returns data with a one-cycle valid pulse.
- A watchdog aborts transactions that are never acknowledged.
- Sits between the cpu core and the memory/cache model.

Parameters:
ADDR_WIDTH, 32, width of all address buses
TIMEOUT, 255, max wait cycles for i_mem_ack before abort; 0 disables the watchdog

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_rd_i  in  1  instruction fetch request, held until o_valid_i
i_addr_i  in  ADDR_WIDTH  fetch address
o_data_in_i  out  32  fetched instruction
o_valid_i  out  1  one-cycle pulse, fetch complete
i_rd_d  in  1  data read request, held until o_valid_d
i_wr_d  in  4  data byte-write enables, held until o_valid_d
i_addr_d  in  ADDR_WIDTH  data address
i_data_wr_d  in  32  write data
o_data_rd_d  out  32  read data
o_valid_d  out  1  one-cycle pulse, data access complete
o_err  out  1  one-cycle pulse with o_valid_i/o_valid_d when the access timed out
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_rd  out  1  memory read strobe
o_mem_wr  out  4  memory byte-write strobes
o_mem_data_wr  out  32  memory write data
i_mem_data_rd  in  32  memory read data, valid when i_mem_ack=1
i_mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = I, so data wins the first tie; watchdog counter 0.
- Reset mid-transaction: strobes drop at the next edge; no valid pulse; the memory-side transaction is abandoned.

States:
- IDLE
  - Samples requests. Instruction request = i_rd_i. Data request = i_rd_d | (|i_wr_d).
  - One request pending: grant it.
  - Both pending: grant the port opposite last_grant.
  - Registered outputs on the edge: o_mem_addr, o_mem_rd, o_mem_wr, o_mem_data_wr. The state becomes BUSY_I or BUSY_D and last_grant updates.
- BUSY_I / BUSY_D
  - Strobes, address and write data are held constant, independent of any requester input changes.
  - Counter increments each cycle.
  - On i_mem_ack:
    - Strobes go to 0 at the next edge; state returns to IDLE.
    - BUSY_I: o_data_in_i <= i_mem_data_rd; o_valid_i=1.
    - BUSY_D read: o_data_rd_d <= i_mem_data_rd.
    - BUSY_D write: o_data_rd_d <= 0.
    - BUSY_D (read or write): o_valid_d=1.

Timing:
- Latency: request seen at edge N -> strobes high after edge N. Ack sampled at edge M -> valid/data after edge M, state IDLE. Next grant strobes after edge M+1.
- Minimum transaction: 3 cycles request-to-valid with same-cycle-next ack.
- o_data_in_i and o_data_rd_d hold their value until that port's next completion.

Data port:
- i_rd_d together with nonzero i_wr_d: treated as a write; o_mem_rd=0.
- Write strobes pass through as-is; byte merging belongs to memory.

Watchdog (TIMEOUT>0):
- If the counter reaches TIMEOUT in BUSY without ack: strobes drop, the owner's valid pulses with o_err=1, data output is 0, state returns to IDLE.
- Ack on the same cycle as the counter reaching TIMEOUT: ack wins, o_err=0.
- Counter clears on every IDLE->BUSY transition.

Requester behaviour:
- A request dropped mid-transaction still completes and still pulses valid; requesters must ignore the pulse.
- A new request from the just-served port in the valid cycle is legal and is arbitrated in IDLE.
- i_mem_ack in IDLE is ignored.

Test Plan:
1. Fetch only: i_rd_i=1, i_addr_i=0x100; mem acks 2 cycles after strobe with 0x00000013 -> o_mem_rd=1 with addr 0x100; o_valid_i pulses once; o_data_in_i=0x00000013; o_valid_d stays 0.
2. Contention after reset: i_rd_i=1 (addr 0x200) and i_rd_d=1 (addr 0x8000) in the same cycle, both held; immediate acks -> data granted first, then fetch; grant order D,I,D,I over 4 transactions.
3. Byte write: i_wr_d=4'b0010, i_addr_d=0x40, i_data_wr_d=0xAABBCCDD -> o_mem_wr=0010, o_mem_rd=0, o_mem_data_wr=0xAABBCCDD; after ack o_valid_d=1, o_data_rd_d=0.
4. Stability: toggle i_addr_d and i_data_wr_d while BUSY_D with ack delayed 5 cycles -> o_mem_addr and o_mem_data_wr unchanged until ack.
5. Timeout: TIMEOUT=4, no ack -> strobes drop after 4 busy cycles; o_valid_d=1 and o_err=1 for one cycle; o_data_rd_d=0. With ack on the 4th cycle -> o_err=0 and data returned.
6. Reset mid-op: assert i_rst 1 cycle while BUSY_I -> all strobes and valids 0 after the edge; a late ack is ignored; the next contended grant goes to data.
